// File: rtl/pulse_meter.sv
// pulse_meter: measures busy_in pulse widths in clock cycles, with saturation,
// abort and optional automatic re-arming.
module pulse_meter #(
    parameter int WIDTH      = 16,
    parameter bit AUTO_REARM = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             abort,
    input  logic             busy_in,
    output logic             measuring,
    output logic             valid,
    output logic [WIDTH-1:0] width,
    output logic             overflow
);
    typedef enum logic [1:0] {IDLE, WAIT, MEASURE} state_t;
    state_t           state;
    logic [WIDTH-1:0] count;
    logic             sticky;
    logic             busy_prev;
    always_comb measuring = (state == WAIT) || (state == MEASURE);
    // busy_prev resets high so a pulse already present at reset release is not a rising edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            sticky    <= 1'b0;
            busy_prev <= 1'b1;
            valid     <= 1'b0;
            width     <= '0;
            overflow  <= 1'b0;
        end else begin
            busy_prev <= busy_in;
            valid     <= 1'b0;
            if (abort)
                state <= IDLE;
            else
                case (state)
                    IDLE:    if (arm) state <= WAIT;
                    WAIT:    if (busy_in && !busy_prev) begin
                                 state  <= MEASURE;
                                 count  <= {{(WIDTH-1){1'b0}}, 1'b1};
                                 sticky <= 1'b0;
                             end
                    MEASURE: if (busy_in) begin
                                 if (&count) sticky <= 1'b1;
                                 else count <= count + 1'b1;
                             end else begin
                                 valid    <= 1'b1;
                                 width    <= count;
                                 overflow <= sticky;
                                 state    <= AUTO_REARM ? WAIT : IDLE;
                             end
                    default: state <= IDLE;
                endcase
        end
    end
endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: directed stimulus with scoreboard queues checked by valid-driven monitors.
module tb_pulse_meter;
    typedef struct {int w; bit o;} exp_t;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        arm = 1'b0, abort = 1'b0, busy_in = 1'b0;
    logic        measuring, valid, overflow;
    logic [3:0]  width;
    logic        arm_b = 1'b0, abort_b = 1'b0, busy_b = 1'b0;
    logic        measuring_b, valid_b, overflow_b;
    logic [15:0] width_b;
    exp_t        q0[$], q1[$];
    int          checks = 0, errors = 0;

    pulse_meter #(.WIDTH(4), .AUTO_REARM(1'b0)) u_dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort), .busy_in(busy_in),
        .measuring(measuring), .valid(valid), .width(width), .overflow(overflow));

    pulse_meter #(.WIDTH(16), .AUTO_REARM(1'b1)) u_ar (
        .clk(clk), .reset(reset), .arm(arm_b), .abort(abort_b), .busy_in(busy_b),
        .measuring(measuring_b), .valid(valid_b), .width(width_b), .overflow(overflow_b));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push0(input int w, input bit o);
        exp_t e;
        e.w = w; e.o = o;
        q0.push_back(e);
    endtask

    task automatic push1(input int w, input bit o);
        exp_t e;
        e.w = w; e.o = o;
        q1.push_back(e);
    endtask

    task automatic do_arm();
        arm = 1'b1; cyc(1); arm = 1'b0;
    endtask

    task automatic pulse(input int n);
        busy_in = 1'b1; cyc(n); busy_in = 1'b0;
    endtask

    always @(negedge clk) begin
        if (valid) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL d0_unexpected_valid width=%0d overflow=%0b required no valid", width, overflow);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("d0_width", int'(width), e.w);
                chk("d0_overflow", int'(overflow), int'(e.o));
            end
        end
    end

    always @(negedge clk) begin
        if (valid_b) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL ar_unexpected_valid width=%0d overflow=%0b required no valid", width_b, overflow_b);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("ar_width", int'(width_b), e.w);
                chk("ar_overflow", int'(overflow_b), int'(e.o));
            end
        end
    end

    initial begin
        arm = 1'b1; busy_in = 1'b1; abort = 1'b1;
        cyc(2);
        chk("rst_valid", int'(valid), 0);
        chk("rst_width", int'(width), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_measuring", int'(measuring), 0);
        chk("rst_measuring_ar", int'(measuring_b), 0);
        abort = 1'b0;
        reset = 1'b1;
        cyc(1); arm = 1'b0;
        chk("armed_at_release", int'(measuring), 1);
        cyc(3); busy_in = 1'b0; cyc(2);
        push0(2, 1'b0); pulse(2); cyc(3);
        chk("idle_after_first", int'(measuring), 0);
        do_arm();
        chk("armed_wait", int'(measuring), 1);
        push0(5, 1'b0); pulse(5); cyc(3);
        chk("idle_after_5", int'(measuring), 0);
        do_arm(); push0(15, 1'b1); pulse(20); cyc(3);
        do_arm(); push0(3, 1'b0);  pulse(3);  cyc(3);
        do_arm(); push0(15, 1'b0); pulse(15); cyc(3);
        do_arm(); push0(15, 1'b1); pulse(16); cyc(3);
        do_arm(); push0(1, 1'b0);  pulse(1);  cyc(5);
        chk("hold_width", int'(width), 1);
        chk("hold_overflow", int'(overflow), 0);
        busy_in = 1'b1; do_arm(); cyc(4); busy_in = 1'b0; cyc(2);
        push0(7, 1'b0); pulse(7); cyc(3);
        do_arm(); busy_in = 1'b1; cyc(2);
        abort = 1'b1; cyc(1); abort = 1'b0;
        chk("abort_measuring", int'(measuring), 0);
        chk("abort_valid", int'(valid), 0);
        cyc(7); busy_in = 1'b0; cyc(3);
        chk("abort_width_kept", int'(width), 7);
        chk("abort_overflow_kept", int'(overflow), 0);
        arm = 1'b1; abort = 1'b1; cyc(1); arm = 1'b0; abort = 1'b0;
        chk("abort_over_arm", int'(measuring), 0);
        arm = 1'b1; cyc(1);
        push0(6, 1'b0); busy_in = 1'b1; cyc(4); arm = 1'b0; cyc(2); busy_in = 1'b0; cyc(3);
        chk("idle_after_arm_ignored", int'(measuring), 0);
        do_arm(); busy_in = 1'b1; cyc(4);
        reset = 1'b0; cyc(1);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_width", int'(width), 0);
        chk("midrst_overflow", int'(overflow), 0);
        chk("midrst_measuring", int'(measuring), 0);
        busy_in = 1'b0; cyc(1); reset = 1'b1; cyc(2);
        arm_b = 1'b1; cyc(1); arm_b = 1'b0;
        push1(1, 1'b0); push1(2, 1'b0); push1(3, 1'b0);
        busy_b = 1'b1; cyc(1); busy_b = 1'b0; cyc(1);
        busy_b = 1'b1; cyc(2); busy_b = 1'b0; cyc(1);
        busy_b = 1'b1; cyc(3); busy_b = 1'b0; cyc(3);
        chk("ar_still_waiting", int'(measuring_b), 1);
        abort_b = 1'b1; cyc(1); abort_b = 1'b0;
        chk("ar_abort_idle", int'(measuring_b), 0);
        cyc(3);
        chk("d0_all_valids_seen", q0.size(), 0);
        chk("ar_all_valids_seen", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
